// File: rtl/vdp_bus_pkg.sv
// Shared encodings for the VDP bus master: command op-codes, VDP mode values and FSM states.
package vdp_bus_pkg;

   localparam logic [1:0] OP_SELECT     = 2'd0;
   localparam logic [1:0] OP_REG_WRITE  = 2'd1;
   localparam logic [1:0] OP_VRAM_WRITE = 2'd2;
   localparam logic [1:0] OP_VRAM_READ  = 2'd3;

   localparam logic [1:0] MODE_SELECT = 2'b00;
   localparam logic [1:0] MODE_REG    = 2'b01;
   localparam logic [1:0] MODE_DATA   = 2'b10;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      HOLD   = 2'd3
   } state_e;

   function automatic logic [1:0] mode_of_op(input logic [1:0] op);
      logic [1:0] mode;
      case (op)
         OP_SELECT:    mode = MODE_SELECT;
         OP_REG_WRITE: mode = MODE_REG;
         default:      mode = MODE_DATA;
      endcase
      return mode;
   endfunction

   // Both VRAM ops share op[1]=1; they are the only ones gated by the settle time.
   function automatic logic is_vram_op(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/vdp_settle_timer.sv
// Loadable saturating down-counter with a zero flag; used both for the VRAM settle
// window and for counting SETUP/STROBE/HOLD phase lengths.
module vdp_settle_timer #(
   parameter int unsigned          WIDTH     = 5,
   parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_b_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   output logic             zero_o
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (count_q != '0) begin
         count_d = count_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_b_i) begin
         count_q <= RESET_VAL;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero_o = (count_q == '0);

endmodule

// File: rtl/vdp_bus_master.sv
// Drives the VDP CPU-side port (mode/read/write/data) from a one-at-a-time command
// stream, with setup/strobe/hold timing and the VRAM tile-slot settle window.
//
// state  | meaning
// IDLE   | cmd_ready high, mode parked at 00, strobes low
// SETUP  | mode/data driven; VRAM ops also wait for the settle window to expire
// STROBE | vdp_write or vdp_read high, mode/data stable
// HOLD   | strobe low, mode/data still held; read response pulses on first cycle
module vdp_bus_master
   import vdp_bus_pkg::*;
#(
   parameter int unsigned SETUP_CYCLES    = 1,
   parameter int unsigned STROBE_CYCLES   = 2,
   parameter int unsigned HOLD_CYCLES     = 1,
   parameter int unsigned VRAM_GAP_CYCLES = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [7:0] cmd_data,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       busy,
   output logic [1:0] vdp_mode,
   output logic       vdp_read,
   output logic       vdp_write,
   output logic [7:0] vdp_wdata,
   input  logic [7:0] vdp_rdata
);

   localparam int unsigned SETTLE_W = $clog2(VRAM_GAP_CYCLES + 1);
   localparam int unsigned PH_MAX_A = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
   localparam int unsigned PH_MAX   = (PH_MAX_A > HOLD_CYCLES) ? PH_MAX_A : HOLD_CYCLES;
   localparam int unsigned PH_W     = $clog2(PH_MAX + 1);

   // Phase timer counts down to zero, so each phase loads its length minus one.
   localparam logic [PH_W-1:0]     SETUP_LD  = PH_W'(SETUP_CYCLES - 1);
   localparam logic [PH_W-1:0]     STROBE_LD = PH_W'(STROBE_CYCLES - 1);
   localparam logic [PH_W-1:0]     HOLD_LD   = PH_W'(HOLD_CYCLES - 1);
   localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(VRAM_GAP_CYCLES);

   state_e      state_q, state_d;
   logic [1:0]  op_q, op_d;
   logic [1:0]  mode_q, mode_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [7:0]  rsp_data_q, rsp_data_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        write_q, write_d;
   logic        read_q, read_d;

   logic            phase_load;
   logic [PH_W-1:0] phase_val;
   logic            phase_zero;
   logic            settle_load;
   logic            settle_zero;

   assign cmd_ready = (state_q == IDLE) && reset;
   assign busy      = (state_q != IDLE);
   assign vdp_mode  = mode_q;
   assign vdp_wdata = wdata_q;
   assign vdp_write = write_q;
   assign vdp_read  = read_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;

   vdp_settle_timer #(
      .WIDTH     (PH_W),
      .RESET_VAL ('0)
   ) u_phase_timer (
      .clk        (clk),
      .rst_b_i    (reset),
      .load_i     (phase_load),
      .load_val_i (phase_val),
      .zero_o     (phase_zero)
   );

   vdp_settle_timer #(
      .WIDTH     (SETTLE_W),
      .RESET_VAL (SETTLE_LD)
   ) u_settle_timer (
      .clk        (clk),
      .rst_b_i    (reset),
      .load_i     (settle_load),
      .load_val_i (SETTLE_LD),
      .zero_o     (settle_zero)
   );

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      mode_d      = mode_q;
      wdata_d     = wdata_q;
      rsp_data_d  = rsp_data_q;
      rsp_valid_d = 1'b0;
      phase_load  = 1'b0;
      phase_val   = '0;
      settle_load = 1'b0;

      case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               op_d       = cmd_op;
               mode_d     = mode_of_op(cmd_op);
               wdata_d    = cmd_data;
               state_d    = SETUP;
               phase_load = 1'b1;
               phase_val  = SETUP_LD;
            end
         end
         SETUP: begin
            if (phase_zero && (!is_vram_op(op_q) || settle_zero)) begin
               state_d    = STROBE;
               phase_load = 1'b1;
               phase_val  = STROBE_LD;
            end
         end
         STROBE: begin
            if (phase_zero) begin
               state_d    = HOLD;
               phase_load = 1'b1;
               phase_val  = HOLD_LD;
               if (op_q == OP_VRAM_READ) begin
                  rsp_data_d  = vdp_rdata;
                  rsp_valid_d = 1'b1;
               end
            end
         end
         HOLD: begin
            if (phase_zero) begin
               state_d     = IDLE;
               mode_d      = MODE_SELECT;
               settle_load = (op_q != OP_SELECT);
            end
         end
         default: state_d = IDLE;
      endcase

      // Strobes are registered from the next state so they rise and fall exactly on phase edges.
      write_d = (state_d == STROBE) && (op_d != OP_VRAM_READ);
      read_d  = (state_d == STROBE) && (op_d == OP_VRAM_READ);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         op_q        <= OP_SELECT;
         mode_q      <= MODE_SELECT;
         wdata_q     <= '0;
         rsp_data_q  <= '0;
         rsp_valid_q <= 1'b0;
         write_q     <= 1'b0;
         read_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         mode_q      <= mode_d;
         wdata_q     <= wdata_d;
         rsp_data_q  <= rsp_data_d;
         rsp_valid_q <= rsp_valid_d;
         write_q     <= write_d;
         read_q      <= read_d;
      end
   end

endmodule

// File: tb/tb_vdp_bus_master.sv
// Directed bench for vdp_bus_master: a command table with hand-computed timing,
// plus sequences for reset behaviour, mid-strobe reset and back-to-back offers.
module tb_vdp_bus_master;

   localparam logic [1:0] SEL  = 2'd0;
   localparam logic [1:0] REGW = 2'd1;
   localparam logic [1:0] VW   = 2'd2;
   localparam logic [1:0] VR   = 2'd3;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = 2'd0;
   logic [7:0] cmd_data = 8'h00;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       busy;
   logic [1:0] vdp_mode;
   logic       vdp_read;
   logic       vdp_write;
   logic [7:0] vdp_wdata;
   logic [7:0] vdp_rdata = 8'h00;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   vdp_bus_master #(
      .SETUP_CYCLES    (1),
      .STROBE_CYCLES   (2),
      .HOLD_CYCLES     (1),
      .VRAM_GAP_CYCLES (16)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .busy      (busy),
      .vdp_mode  (vdp_mode),
      .vdp_read  (vdp_read),
      .vdp_write (vdp_write),
      .vdp_wdata (vdp_wdata),
      .vdp_rdata (vdp_rdata)
   );

   // Minimal vdp: commits a write on the strobe falling edge using the values seen
   // while the strobe was high. REG_WRITE loads the VRAM address, VRAM writes auto-increment by 2.
   logic       prev_wr = 1'b0;
   logic [1:0] prev_mode = 2'b00;
   logic [7:0] prev_data = 8'h00;
   logic [7:0] sel_reg = 8'h00;
   logic [7:0] addr_reg = 8'h00;
   logic [7:0] vram [0:255];

   always @(negedge clk) begin
      if (prev_wr && !vdp_write) begin
         case (prev_mode)
            2'b00: sel_reg = prev_data;
            2'b01: addr_reg = prev_data;
            2'b10: begin
               vram[addr_reg] = prev_data;
               addr_reg = addr_reg + 8'd2;
            end
            default: ;
         endcase
      end
      prev_wr   = vdp_write;
      prev_mode = vdp_mode;
      prev_data = vdp_wdata;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   typedef struct {
      logic [1:0] op;
      logic [7:0] data;
      logic [7:0] rdata;
      logic [1:0] mode;
      bit         is_read;
      int         rise;   // cycles from start of accept cycle to strobe rise
      int         idle;   // cycles from start of accept cycle to cmd_ready again
      int         rsp;    // number of rsp_valid pulses
   } vec_t;

   // Offer one command at a negedge, then watch the whole transaction until IDLE.
   task automatic run_vec(input vec_t v, input string tag);
      int rise = -1;
      int idle = -1;
      int width = 0;
      int wrong = 0;
      int mode_err = 0;
      int data_err = 0;
      int ready_err = 0;
      int rsp_n = 0;
      logic [7:0] rsp_got = 8'h00;
      logic strobe;
      logic other;
      vdp_rdata = ~v.rdata;
      cmd_op    = v.op;
      cmd_data  = v.data;
      cmd_valid = 1'b1;
      #1;
      check({tag, " cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_data  = ~v.data;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         strobe = v.is_read ? vdp_read : vdp_write;
         other  = v.is_read ? vdp_write : vdp_read;
         if (busy) begin
            if (vdp_mode !== v.mode) mode_err++;
            if (vdp_wdata !== v.data) data_err++;
            if (cmd_ready !== 1'b0) ready_err++;
         end
         if (strobe) begin
            if (rise < 0) rise = k;
            width++;
            if (v.is_read) vdp_rdata = v.rdata;
         end
         if (other) wrong++;
         if (rsp_valid) begin
            rsp_n++;
            rsp_got = rsp_data;
         end
         if (!busy) begin
            idle = k;
            break;
         end
      end
      check({tag, " strobe rise"}, rise + 1, v.rise);
      check({tag, " strobe width"}, width, 2);
      check({tag, " back to idle"}, idle + 1, v.idle);
      check({tag, " mode errors"}, mode_err, 0);
      check({tag, " data errors"}, data_err, 0);
      check({tag, " wrong strobe"}, wrong, 0);
      check({tag, " ready while busy"}, ready_err, 0);
      check({tag, " rsp pulses"}, rsp_n, v.rsp);
      if (v.rsp != 0) check({tag, " rsp_data"}, {24'd0, rsp_got}, {24'd0, v.rdata});
      check({tag, " idle mode"}, {30'd0, vdp_mode}, 32'd0);
   endtask

   vec_t vecs [8];

   initial begin
      int acc_n;
      int acc0;
      int acc1;
      int wd_err;
      int waited;
      vec_t v;

      vecs[0] = '{SEL,  8'h0C, 8'h00, 2'b00, 1'b0, 2,  5,  0};
      vecs[1] = '{REGW, 8'h00, 8'h00, 2'b01, 1'b0, 2,  5,  0};
      vecs[2] = '{VW,   8'hAA, 8'h00, 2'b10, 1'b0, 17, 20, 0};
      vecs[3] = '{VW,   8'h55, 8'h00, 2'b10, 1'b0, 17, 20, 0};
      vecs[4] = '{VR,   8'h99, 8'h3C, 2'b10, 1'b1, 17, 20, 1};
      vecs[5] = '{SEL,  8'h07, 8'h00, 2'b00, 1'b0, 2,  5,  0};
      vecs[6] = '{VR,   8'h00, 8'hC3, 2'b10, 1'b1, 12, 15, 1};
      vecs[7] = '{REGW, 8'h81, 8'h00, 2'b01, 1'b0, 2,  5,  0};

      // Reset held for 4 cycles.
      reset = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("reset outputs", {14'd0, vdp_mode, vdp_read, vdp_write, vdp_wdata, rsp_valid, rsp_data, busy},
            32'd0);
      check("reset cmd_ready", {31'd0, cmd_ready}, 32'd0);
      reset = 1'b1;
      #1;
      check("release cmd_ready", {31'd0, cmd_ready}, 32'd1);
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         v = vecs[i];
         run_vec(v, $sformatf("vec%0d", i));
      end

      check("vdp select reg", {24'd0, sel_reg}, 32'h07);
      check("vram[0]", {24'd0, vram[0]}, 32'hAA);
      check("vram[2]", {24'd0, vram[2]}, 32'h55);

      // cmd_valid held high with data toggling: accepts only when idle.
      acc_n = 0;
      acc0 = -1;
      acc1 = -1;
      wd_err = 0;
      cmd_op = SEL;
      cmd_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         cmd_data = 8'h10 + 8'(c);
         #1;
         if (cmd_ready) begin
            if (acc_n == 0) acc0 = c;
            else if (acc_n == 1) acc1 = c;
            acc_n++;
         end
         @(posedge clk);
         #1;
         if (vdp_wdata !== ((c < 5) ? 8'h10 : 8'h15)) wd_err++;
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      check("stream accept count", acc_n, 2);
      check("stream first accept", acc0, 0);
      check("stream second accept", acc1, 5);
      check("stream wdata errors", wd_err, 0);
      waited = 0;
      while (busy && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check("stream drains", {31'd0, busy}, 32'd0);

      // Reset asserted during the strobe of a VRAM write.
      cmd_op = VW;
      cmd_data = 8'h5A;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (!vdp_write && waited < 40);
      check("mid-op strobe seen", {31'd0, vdp_write}, 32'd1);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("mid-op reset write", {31'd0, vdp_write}, 32'd0);
      check("mid-op reset mode", {30'd0, vdp_mode}, 32'd0);
      check("mid-op reset busy", {31'd0, busy}, 32'd0);
      check("mid-op reset ready", {31'd0, cmd_ready}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      v = '{VW, 8'h66, 8'h00, 2'b10, 1'b0, 17, 20, 0};
      run_vec(v, "post-reset vram");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
